// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Serial program loader. Collects bytes from a valid/ready byte
//            stream, assembles them little-endian into instruction words and
//            writes each word to instruction memory with a one-cycle strobe.
//            Optional trailing 32-bit checksum check (macro LOADER_CHECKSUM_EN).
// Ports    : clk, rst_n (async, active-low)
//            start, num_words[7:0]      - load request / word count
//            byte_in[7:0], byte_valid   - serial byte stream in
//            byte_ready                 - loader accepts a byte this cycle
//            wr_en, wr_addr, wr_data    - instruction memory write port
//            busy, done, err            - status
// Macro    : LOADER_CHECKSUM_EN - enables CHECK state and running word sum
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       num_words,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK   = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_word_cnt;
    logic [7:0]  r_num_words;
    logic [23:0] r_asm;        // lower three bytes of the word being built
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_sum;
`endif

    logic        w_xfer;
    logic        w_too_big;
    logic [31:0] w_word;

    // Status strobes are pure decodes of the state register.
`ifdef LOADER_CHECKSUM_EN
    assign byte_ready = (r_state == S_COLLECT) || (r_state == S_CHECK);
    assign busy       = (r_state == S_COLLECT) || (r_state == S_WRITE) ||
                        (r_state == S_CHECK);
`else
    assign byte_ready = (r_state == S_COLLECT);
    assign busy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
`endif
    assign wr_en      = (r_state == S_WRITE);

    assign w_xfer     = byte_valid && byte_ready;
    assign w_too_big  = (32'(num_words) > DEPTH);
    // Completed word when the fourth byte arrives this cycle.
    assign w_word     = {byte_in, r_asm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= 8'd0;
            r_num_words <= 8'd0;
            r_asm       <= 24'd0;
            wr_addr     <= '0;
            wr_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_byte_cnt  <= 2'd0;
                        r_word_cnt  <= 8'd0;
                        r_num_words <= num_words;
                        wr_addr     <= '0;
                        done        <= 1'b0;
                        err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum       <= 32'd0;
`endif
                        if (num_words == 8'd0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else if (w_too_big) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_xfer) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_asm[7:0]   <= byte_in;
                            2'd1: r_asm[15:8]  <= byte_in;
                            2'd2: r_asm[23:16] <= byte_in;
                            default: begin
                                // Address and data are loaded on entry to WRITE
                                // so they stay stable for the strobe and after.
                                wr_data <= WIDTH'(w_word);
                                wr_addr <= WIDTH'({r_word_cnt, 2'b00});
`ifdef LOADER_CHECKSUM_EN
                                r_sum   <= r_sum + w_word;
`endif
                                r_state <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    r_word_cnt <= r_word_cnt + 8'd1;
                    if ((r_word_cnt + 8'd1) == r_num_words) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHECK;
`else
                        r_state <= S_DONE;
                        done    <= 1'b1;
`endif
                    end else begin
                        r_state <= S_COLLECT;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_xfer) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_asm[7:0]   <= byte_in;
                            2'd1: r_asm[15:8]  <= byte_in;
                            2'd2: r_asm[23:16] <= byte_in;
                            default: begin
                                if (w_word != r_sum) begin
                                    err <= 1'b1;
                                end
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
`endif

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_loader
// Purpose  : Self-checking bench for inst_mem_loader. Expected writes are
//            derived from the byte stream itself (word i = bytes 4i..4i+3,
//            little-endian, at address 4i).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 128;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       num_words = 8'd0;
    logic [7:0]       byte_in = 8'd0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];
    int          mon_cyc[$];

    inst_mem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with wr_en high is one memory write.
    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
            mon_cyc.push_back(cyc);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] word_of(input logic [7:0] b[$], input int i);
        return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
    endfunction

    function automatic logic [31:0] sum_of(input logic [7:0] b[$], input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) s = s + word_of(b, i);
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
    endtask

    task automatic do_start(input logic [7:0] nw);
        @(posedge clk); #1;
        clear_mon();
        num_words = nw;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int stall, output bit ok);
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // stall < 0 selects a random stall of 0..3 cycles per byte
    task automatic run_load(input logic [7:0] nw, input logic [7:0] bq[$],
                            input int stall, output bit ok);
        bit b_ok;
        ok = 1'b1;
        do_start(nw);
        foreach (bq[i]) begin
            push_byte(bq[i], (stall < 0) ? int'($urandom_range(0, 3)) : stall, b_ok);
            ok &= b_ok;
        end
        wait_done(b_ok);
        ok &= b_ok;
    endtask

    task automatic append_cks(inout logic [7:0] bq[$], input int n);
`ifdef LOADER_CHECKSUM_EN
        logic [31:0] s;
        s = sum_of(bq, n);
        for (int k = 0; k < 4; k++) bq.push_back(s[8*k +: 8]);
`else
        if (n < 0) bq.delete();
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [6:0] v;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        v = {byte_ready, wr_en, busy, done, err, |wr_addr, |wr_data};
        n_checks++;
        if (v !== 7'd0) $display("FAIL reset_outputs got=%b exp=0000000", v);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({byte_ready, busy, wr_en, done} !== 4'd0)
            $display("FAIL idle_after_reset got=%b exp=0000", {byte_ready, busy, wr_en, done});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0] bq[$] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        bit ok;
        append_cks(bq, 2);
        run_load(8'd2, bq, 0, ok);
        n_checks++;
        if (!ok) $display("FAIL directed_timeout got=0 exp=1"); else n_pass++;
        n_checks++;
        if (mon_addr.size() !== 2) $display("FAIL directed_nwrites got=%0d exp=2", mon_addr.size());
        else n_pass++;
        if (mon_addr.size() == 2) begin
            n_checks++;
            if (mon_addr[0] !== 32'h0 || mon_data[0] !== 32'h00000013)
                $display("FAIL directed_w0 got=%h/%h exp=0/00000013", mon_addr[0], mon_data[0]);
            else n_pass++;
            n_checks++;
            if (mon_addr[1] !== 32'h4 || mon_data[1] !== 32'h00100093)
                $display("FAIL directed_w1 got=%h/%h exp=4/00100093", mon_addr[1], mon_data[1]);
            else n_pass++;
            n_checks++;
            if (mon_cyc[1] - mon_cyc[0] !== 5)
                $display("FAIL directed_interval got=%0d exp=5", mon_cyc[1] - mon_cyc[0]);
            else n_pass++;
        end
        n_checks++;
        if ({done, err, busy, byte_ready} !== 4'b1000)
            $display("FAIL directed_status got=%b exp=1000", {done, err, busy, byte_ready});
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] bq[$];
        bit ok;
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        append_cks(bq, 3);
        run_load(8'd3, bq, 3, ok);
        n_checks++;
        if (!ok || mon_addr.size() !== 3)
            $display("FAIL stall_nwrites got=%0d exp=3 ok=%0d", mon_addr.size(), ok);
        else n_pass++;
        for (int i = 0; i < 3 && i < mon_addr.size(); i++) begin
            n_checks++;
            if (mon_addr[i] !== 32'(4*i) || mon_data[i] !== word_of(bq, i))
                $display("FAIL stall_w%0d got=%h/%h exp=%h/%h", i, mon_addr[i], mon_data[i],
                         32'(4*i), word_of(bq, i));
            else n_pass++;
        end
        n_checks++;
        if ({done, err} !== 2'b10) $display("FAIL stall_status got=%b exp=10", {done, err});
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] bq[$];
            bit ok;
            int nw;
            nw = $urandom_range(1, 10);
            for (int i = 0; i < 4*nw; i++) bq.push_back(8'($urandom));
            append_cks(bq, nw);
            run_load(8'(nw), bq, -1, ok);
            n_checks++;
            if (!ok || mon_addr.size() !== nw || err !== 1'b0)
                $display("FAIL random%0d_count got=%0d exp=%0d ok=%0d err=%b", it, mon_addr.size(), nw, ok, err);
            else n_pass++;
            for (int i = 0; i < nw && i < mon_addr.size(); i++) begin
                n_checks++;
                if (mon_addr[i] !== 32'(4*i) || mon_data[i] !== word_of(bq, i))
                    $display("FAIL random%0d_w%0d got=%h/%h exp=%h/%h", it, i, mon_addr[i],
                             mon_data[i], 32'(4*i), word_of(bq, i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_limits();
        logic [7:0] bq[$];
        bit ok;
        int bad;
        do_start(8'd200);
        @(negedge clk);
        n_checks++;
        if ({done, err, busy} !== 3'b110) $display("FAIL over200_status got=%b exp=110", {done, err, busy});
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if (mon_addr.size() !== 0) $display("FAIL over200_writes got=%0d exp=0", mon_addr.size());
        else n_pass++;

        do_start(8'd0);
        @(negedge clk);
        n_checks++;
        if ({done, err, busy} !== 3'b100) $display("FAIL zero_status got=%b exp=100", {done, err, busy});
        else n_pass++;

        do_start(8'(DEPTH + 1));
        @(negedge clk);
        n_checks++;
        if ({done, err} !== 2'b11) $display("FAIL depth_plus1 got=%b exp=11", {done, err});
        else n_pass++;

        for (int i = 0; i < 4*DEPTH; i++) bq.push_back(8'($urandom));
        append_cks(bq, DEPTH);
        run_load(8'(DEPTH), bq, 0, ok);
        n_checks++;
        if (!ok || mon_addr.size() !== DEPTH || err !== 1'b0)
            $display("FAIL full_count got=%0d exp=%0d ok=%0d", mon_addr.size(), DEPTH, ok);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < mon_addr.size(); i++)
            if (mon_addr[i] !== 32'(4*i) || mon_data[i] !== word_of(bq, i)) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL full_words got=%0d bad exp=0", bad);
        else n_pass++;
        n_checks++;
        if (wr_addr !== 32'(4*(DEPTH-1)))
            $display("FAIL full_last_addr got=%h exp=%h", wr_addr, 32'(4*(DEPTH-1)));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] bq[$];
        logic [7:0] b2[$];
        bit ok;
        logic [6:0] v;
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        do_start(8'd2);
        for (int i = 0; i < 6; i++) push_byte(bq[i], 0, ok);
        rst_n = 1'b0;
        #1;
        v = {byte_ready, wr_en, busy, done, err, |wr_addr, |wr_data};
        n_checks++;
        if (v !== 7'd0) $display("FAIL midreset_outputs got=%b exp=0000000", v);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        n_checks++;
        if (mon_addr.size() !== 0 || busy !== 1'b0)
            $display("FAIL midreset_quiet got=%0d writes busy=%b exp=0 writes busy=0", mon_addr.size(), busy);
        else n_pass++;
        for (int i = 0; i < 4; i++) b2.push_back(8'($urandom));
        append_cks(b2, 1);
        run_load(8'd1, b2, -1, ok);
        n_checks++;
        if (!ok || mon_addr.size() !== 1 || mon_addr[0] !== 32'h0 || mon_data[0] !== word_of(b2, 0))
            $display("FAIL midreset_reload got=%0d writes addr=%h data=%h exp=1 writes addr=0 data=%h",
                     mon_addr.size(), mon_addr[0], mon_data[0], word_of(b2, 0));
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        logic [7:0] bq[$];
        bit ok;
        bit b_ok;
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        append_cks(bq, 2);
        do_start(8'd2);
        ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_byte(bq[i], 0, b_ok);
            ok &= b_ok;
        end
        num_words = 8'd5;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) $display("FAIL ignstart_busy got=%b exp=10", {busy, done});
        else n_pass++;
        for (int i = 2; i < bq.size(); i++) begin
            push_byte(bq[i], 1, b_ok);
            ok &= b_ok;
        end
        wait_done(b_ok);
        ok &= b_ok;
        n_checks++;
        if (!ok || mon_addr.size() !== 2 || err !== 1'b0)
            $display("FAIL ignstart_count got=%0d exp=2 ok=%0d err=%b", mon_addr.size(), ok, err);
        else n_pass++;
        for (int i = 0; i < 2 && i < mon_addr.size(); i++) begin
            n_checks++;
            if (mon_addr[i] !== 32'(4*i) || mon_data[i] !== word_of(bq, i))
                $display("FAIL ignstart_w%0d got=%h/%h exp=%h/%h", i, mon_addr[i], mon_data[i],
                         32'(4*i), word_of(bq, i));
            else n_pass++;
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] bq[$] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00};
        bit ok;
        run_load(8'd2, bq, 0, ok);
        n_checks++;
        if (!ok || {done, err} !== 2'b11 || mon_addr.size() !== 2)
            $display("FAIL cks_bad got=%b writes=%0d exp=11 writes=2", {done, err}, mon_addr.size());
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_limits();
        test_reset_mid();
        test_start_ignored();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction word and address width.
REQ-002 SHALL have parameter DEPTH, default 128, number of instruction words the target memory holds.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  load request pulse, honoured only in IDLE or DONE.
REQ-006 SHALL have port num_words  input  8  words to load, sampled on accepted start.
REQ-007 SHALL have port byte_in  input  8  serial program byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in valid.
REQ-009 SHALL have port byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 SHALL have port wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-011 SHALL have port wr_addr  output  WIDTH  byte address, always a multiple of 4.
REQ-012 SHALL have port wr_data  output  WIDTH  assembled instruction word.
REQ-013 SHALL have port busy  output  1  high in COLLECT, WRITE, CHECK.
REQ-014 SHALL have port done  output  1  load finished, held until next accepted start.
REQ-015 SHALL have port err  output  1  load fault, held until next accepted start.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-017 Accepted start SHALL clear done/err, zero word counter, byte counter and wr_addr.
REQ-018 On start with num_words==0: next state DONE, no writes.
REQ-019 On start with num_words>DEPTH: err=1, next state DONE, no writes.
REQ-020 Otherwise next state COLLECT.
REQ-021 Byte transfer SHALL occur only on a cycle with byte_valid and byte_ready both high.
REQ-022 byte_ready SHALL be 1 only in COLLECT and CHECK; 0 in IDLE, WRITE, DONE.
REQ-023 Byte k (k=0..3) of a word SHALL occupy wr_data bits [8k+7:8k] (little-endian).
REQ-024 Fourth accepted byte SHALL move COLLECT->WRITE; wr_en=1 for exactly the following cycle.
REQ-025 After WRITE: word counter+1, wr_addr+4; when counter reaches num_words go CHECK (macro on) or DONE, else COLLECT.
REQ-026 Throughput: minimum 5 cycles per word; byte_valid stalls SHALL extend COLLECT without data loss.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 wr_addr and wr_data SHALL hold their last values outside WRITE; wr_en=0 outside WRITE.
REQ-029 wr_addr SHALL never exceed 4*(DEPTH-1).

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE; byte_ready, wr_en, busy, done, err, wr_addr, wr_data and all counters =0.
REQ-031 Reset mid-load SHALL discard any partial word; no wr_en pulse after rst_n deasserts until a new start.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: loader keeps 32-bit modulo-2^32 sum of all written words; CHECK accepts 4 more bytes (little-endian), no write; mismatch sets err=1; then DONE.
REQ-033 Macro LOADER_CHECKSUM_EN undefined: no CHECK state, no sum logic; last WRITE goes directly to DONE.

Verification
REQ-034 Reset, start, num_words=2, bytes 13 00 00 00 93 00 10 00 -> writes (0x0,0x00000013),(0x4,0x00100093); done=1, err=0.
REQ-035 num_words=3, byte_valid low 3 cycles between every byte -> same 3 words at 0x0/0x4/0x8, no extra wr_en.
REQ-036 num_words=200 -> no wr_en, done=1, err=1 next cycle; num_words=0 -> done=1, err=0.
REQ-037 rst_n low after 6 of 8 bytes -> all outputs 0; new start with 1 word writes to addr 0x0.
REQ-038 LOADER_CHECKSUM_EN, words 0x00000013,0x00100093, checksum bytes A6 00 10 00 -> err=0; checksum 00 00 00 00 -> err=1.
REQ-039 start pulsed mid-COLLECT -> ignored, load continues unaffected.
